carrier_nco_derotator: RTL

- Phase-rotating front end of the MPSK coherent demodulator. Sits directly upstream of carrierWaveSync.
- Accumulates a carrier frequency word in an NCO phase accumulator, adds a phase offset, and derotates each complex baseband sample with a pipelined CORDIC.
- Its derotated I/Q outputs drive carrierWaveSync signal_I/signal_Q. The loop filter closes the loop through freq_word/phase_offset.

---
 rtl/carrier_nco_derotator.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/carrier_nco_derotator.sv
// Carrier NCO and pipelined CORDIC derotator: multiplies each complex sample by
// exp(-j*theta), where theta is the NCO accumulator plus a static phase offset.
module carrier_nco_derotator #(
  parameter int SYM_WIDTH   = 1,
  parameter int INT_WIDTH   = 3,
  parameter int DEC_WIDTH   = 14,
  parameter int PHASE_WIDTH = 16,
  parameter int ITER        = 12,
  parameter logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] COMP = 18'h26DD
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic                                        in_valid,
  input  logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0]    in_I,
  input  logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0]    in_Q,
  input  logic [PHASE_WIDTH-1:0]                      freq_word,
  input  logic [PHASE_WIDTH-1:0]                      phase_offset,
  input  logic                                        acc_clr,
  output logic                                        out_valid,
  output logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0]    out_I,
  output logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0]    out_Q
);

  localparam int W   = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
  localparam int XW  = W + 2;
  localparam int PW  = PHASE_WIDTH;
  localparam int ZW  = PHASE_WIDTH + 1;
  localparam int PRW = XW + W + 1;

  localparam logic signed [PRW-1:0] RND  = {{(PRW-DEC_WIDTH){1'b0}}, 1'b1, {(DEC_WIDTH-1){1'b0}}};
  localparam logic signed [PRW-1:0] MAXV = {{(PRW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PRW-1:0] MINV = {{(PRW-W+1){1'b1}}, {(W-1){1'b0}}};

  // atan(2^-i) in phase units where 2^16 is one full turn
  function automatic logic [ZW-1:0] atan_lut(input int i);
    logic [15:0] v;
    case (i)
      0:       v = 16'd8192;
      1:       v = 16'd4836;
      2:       v = 16'd2555;
      3:       v = 16'd1297;
      4:       v = 16'd651;
      5:       v = 16'd326;
      6:       v = 16'd163;
      7:       v = 16'd81;
      8:       v = 16'd41;
      9:       v = 16'd20;
      10:      v = 16'd10;
      11:      v = 16'd5;
      12:      v = 16'd3;
      13:      v = 16'd1;
      14:      v = 16'd1;
      default: v = 16'd0;
    endcase
    return ZW'(v);
  endfunction

  // Round half-up, drop the fractional bits, clamp to the W-bit signed range
  function automatic logic [W-1:0] sat_round(input logic signed [PRW-1:0] p);
    logic signed [PRW-1:0] r;
    logic [W-1:0]          s;
    r = (p + RND) >>> DEC_WIDTH;
    if (r > MAXV) begin
      s = MAXV[W-1:0];
    end else if (r < MINV) begin
      s = MINV[W-1:0];
    end else begin
      s = r[W-1:0];
    end
    return s;
  endfunction

  logic [PW-1:0]          acc_r;
  logic [PW-1:0]          theta_s;
  logic signed [XW-1:0]   i_ext_s, q_ext_s, x0_s, y0_s;
  logic signed [ZW-1:0]   z0_s;

  logic [ITER:0]          v_r;
  logic signed [XW-1:0]   x_r [0:ITER];
  logic signed [XW-1:0]   y_r [0:ITER];
  logic signed [ZW-1:0]   z_r [0:ITER-1];

  logic                   vc_r;
  logic signed [PRW-1:0]  px_r, py_r;
  logic signed [PRW-1:0]  comp_s;

  assign comp_s = PRW'(signed'({1'b0, COMP}));

  // NCO phase accumulator; a clear wins over an increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r <= {PW{1'b0}};
    end else if (acc_clr) begin
      acc_r <= {PW{1'b0}};
    end else if (in_valid) begin
      acc_r <= acc_r + freq_word;
    end
  end

  // Sample angle from the pre-update accumulator and coarse quadrant rotation
  always_comb begin
    theta_s = acc_r + phase_offset;
    i_ext_s = {{2{in_I[W-1]}}, in_I};
    q_ext_s = {{2{in_Q[W-1]}}, in_Q};
    case (theta_s[PW-1 -: 2])
      2'b00:   begin x0_s = i_ext_s;                  y0_s = q_ext_s;                  end
      2'b01:   begin x0_s = q_ext_s;                  y0_s = {XW{1'b0}} - i_ext_s;     end
      2'b10:   begin x0_s = {XW{1'b0}} - i_ext_s;     y0_s = {XW{1'b0}} - q_ext_s;     end
      2'b11:   begin x0_s = {XW{1'b0}} - q_ext_s;     y0_s = i_ext_s;                  end
      default: begin x0_s = i_ext_s;                  y0_s = q_ext_s;                  end
    endcase
    z0_s = {3'b000, theta_s[PW-3:0]};
  end

  // Stage 0 register: quadrant-corrected vector and residual angle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_r[0] <= 1'b0;
      x_r[0] <= {XW{1'b0}};
      y_r[0] <= {XW{1'b0}};
      z_r[0] <= {ZW{1'b0}};
    end else begin
      v_r[0] <= in_valid;
      if (in_valid) begin
        x_r[0] <= x0_s;
        y_r[0] <= y0_s;
        z_r[0] <= z0_s;
      end
    end
  end

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    // Micro-rotation i drives the residual angle toward zero
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v_r[i+1] <= 1'b0;
        x_r[i+1] <= {XW{1'b0}};
        y_r[i+1] <= {XW{1'b0}};
      end else begin
        v_r[i+1] <= v_r[i];
        if (v_r[i]) begin
          if (z_r[i][ZW-1]) begin
            x_r[i+1] <= x_r[i] - (y_r[i] >>> i);
            y_r[i+1] <= y_r[i] + (x_r[i] >>> i);
          end else begin
            x_r[i+1] <= x_r[i] + (y_r[i] >>> i);
            y_r[i+1] <= y_r[i] - (x_r[i] >>> i);
          end
        end
      end
    end

    // The last stage only needs the sign of its incoming angle
    if (i < ITER - 1) begin : g_z
      localparam logic signed [ZW-1:0] ATAN = atan_lut(i);
      // Residual angle update for stage i
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          z_r[i+1] <= {ZW{1'b0}};
        end else if (v_r[i]) begin
          z_r[i+1] <= z_r[i][ZW-1] ? (z_r[i] + ATAN) : (z_r[i] - ATAN);
        end
      end
    end
  end

  // CORDIC gain compensation at full product width
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vc_r <= 1'b0;
      px_r <= {PRW{1'b0}};
      py_r <= {PRW{1'b0}};
    end else begin
      vc_r <= v_r[ITER];
      if (v_r[ITER]) begin
        px_r <= PRW'(x_r[ITER]) * comp_s;
        py_r <= PRW'(y_r[ITER]) * comp_s;
      end
    end
  end

  // Output register holds the last sample between strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_I     <= {W{1'b0}};
      out_Q     <= {W{1'b0}};
    end else begin
      out_valid <= vc_r;
      if (vc_r) begin
        out_I <= sat_round(px_r);
        out_Q <= sat_round(py_r);
      end
    end
  end

endmodule
